// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter: FSM states, grant
// identifiers and the latency counter width.
package mem_arb_pkg;

    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } arb_state_e;

    typedef enum logic {
        INST,
        DATA
    } grant_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between the instruction and data ports.
// With MEM_ARB_RR_EN defined, ties alternate based on the previous grant.
module mem_arb_pick (
    input  logic i_ce,
    input  logic d_ce,
`ifdef MEM_ARB_RR_EN
    input  logic last_grant_data,
`endif
    output logic req_valid,
    output logic grant_data
);

    always_comb begin
        req_valid  = i_ce | d_ce;
        grant_data = d_ce;
`ifdef MEM_ARB_RR_EN
        // On a tie, the port that did not win last time goes first
        if (i_ce && d_ce) begin
            grant_data = ~last_grant_data;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU instruction-fetch and load/store accesses onto one synchronous
// memory port. Optional round-robin tie-breaking is enabled by MEM_ARB_RR_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_ce,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ready,
    input  logic                d_ce,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_sel,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                stallreq_if,
    output logic                stallreq_mem,
    output logic                mem_ce,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_sel,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

    arb_state_e          state, state_nxt;
    grant_e              grant, grant_nxt;
    logic [LAT_W-1:0]    lat_cnt, lat_nxt;
    logic                ce_nxt, we_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;
    logic [DATA_W/8-1:0] sel_nxt;
    logic [DATA_W-1:0]   i_rdata_nxt, d_rdata_nxt;
    logic                i_ready_nxt, d_ready_nxt;
    logic                pick_valid, pick_data;
`ifdef MEM_ARB_RR_EN
    grant_e              last_grant, last_nxt;
`endif

    assign stallreq_if  = i_ce & ~i_ready;
    assign stallreq_mem = d_ce & ~d_ready;

    mem_arb_pick u_pick (
        .i_ce            (i_ce),
        .d_ce            (d_ce),
`ifdef MEM_ARB_RR_EN
        .last_grant_data (last_grant == DATA),
`endif
        .req_valid       (pick_valid),
        .grant_data      (pick_data)
    );

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        lat_nxt     = lat_cnt;
        ce_nxt      = mem_ce;
        we_nxt      = mem_we;
        addr_nxt    = mem_addr;
        wdata_nxt   = mem_wdata;
        sel_nxt     = mem_sel;
        i_rdata_nxt = i_rdata;
        d_rdata_nxt = d_rdata;
        i_ready_nxt = 1'b0;
        d_ready_nxt = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_nxt    = last_grant;
`endif
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = ISSUE;
                    grant_nxt = pick_data ? DATA : INST;
                    lat_nxt   = '0;
                    ce_nxt    = 1'b1;
                    if (pick_data) begin
                        we_nxt    = d_we;
                        addr_nxt  = d_addr;
                        wdata_nxt = d_wdata;
                        sel_nxt   = d_sel;
                    end else begin
                        we_nxt    = 1'b0;
                        addr_nxt  = i_addr;
                    end
`ifdef MEM_ARB_RR_EN
                    last_nxt = pick_data ? DATA : INST;
`endif
                end
            end
            ISSUE: begin
                // Writes complete after one cycle; reads wait out the memory latency
                if (mem_we || lat_cnt == LAT_LAST) begin
                    state_nxt = DONE;
                    ce_nxt    = 1'b0;
                    we_nxt    = 1'b0;
                    lat_nxt   = '0;
                    if (grant == DATA) begin
                        d_ready_nxt = 1'b1;
                        if (!mem_we) begin
                            d_rdata_nxt = mem_rdata;
                        end
                    end else begin
                        i_ready_nxt = 1'b1;
                        i_rdata_nxt = mem_rdata;
                    end
                end else begin
                    lat_nxt = lat_cnt + LAT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            grant     <= INST;
            lat_cnt   <= '0;
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_sel   <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant <= INST;
`endif
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            lat_cnt   <= lat_nxt;
            mem_ce    <= ce_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            mem_sel   <= sel_nxt;
            i_rdata   <= i_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
            i_ready   <= i_ready_nxt;
            d_ready   <= d_ready_nxt;
`ifdef MEM_ARB_RR_EN
            last_grant <= last_nxt;
`endif
        end
    end

endmodule
